// File: rtl/rr_ack_arbiter.sv
// rr_ack_arbiter: per-slave ack router for a 2-master / 2-slave fabric.
// Forwards ack_in to one waiting master; round-robin breaks ties.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   s_no                - index of the slave this instance serves
//   ack_in              - ack from the served slave
//   sfor0, sfor1        - slave index targeted by master 0 / 1
//   req_stat0/1         - master request status (NO_REQ/WAIT/W_ACK/W_DATA)
//   ack0, ack1          - ack routed to master 0 / 1 (combinational)
//   ack_err             - registered orphan-ack flag
//                         (present only when RR_ACK_ERR_EN is defined)
//
// Optional feature macro: RR_ACK_ERR_EN
module rr_ack_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_no,
    input  logic       ack_in,
    input  logic       sfor0,
    input  logic       sfor1,
    input  logic [1:0] req_stat0,
    input  logic [1:0] req_stat1,
    output logic       ack0,
    output logic       ack1
`ifdef RR_ACK_ERR_EN
    ,
    output logic       ack_err
`endif
);

    localparam logic [1:0] NO_REQ = 2'd0;
    localparam logic [1:0] WAIT   = 2'd1;
    localparam logic [1:0] W_ACK  = 2'd2;
    localparam logic [1:0] W_DATA = 2'd3;

    logic elig0;
    logic elig1;
    // prio=0 favours master 0 on a tie, prio=1 favours master 1
    logic prio;

    assign elig0 = (req_stat0 == W_ACK) && (sfor0 == s_no);
    assign elig1 = (req_stat1 == W_ACK) && (sfor1 == s_no);

    always_comb begin
        ack0 = 1'b0;
        ack1 = 1'b0;
        if (!rst && ack_in) begin
            ack0 = elig0 && (!elig1 || !prio);
            ack1 = elig1 && (!elig0 || prio);
        end
    end

    // The master just served always loses the next tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (ack0) begin
            prio <= 1'b1;
        end else if (ack1) begin
            prio <= 1'b0;
        end
    end

`ifdef RR_ACK_ERR_EN
    // Flag a slave ack that no master was waiting for, one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_err <= 1'b0;
        end else begin
            ack_err <= ack_in && !elig0 && !elig1;
        end
    end
`endif

    // Only W_ACK is eligible; the other encodings exist for readability.
    logic unused_enc;
    assign unused_enc = ^{NO_REQ, WAIT, W_DATA};

endmodule

// File: tb/tb_rr_ack_arbiter.sv
// tb_rr_ack_arbiter: scoreboard bench for rr_ack_arbiter.
// Driver pushes model expectations; monitor pops and compares.
module tb_rr_ack_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_no = 1'b0;
    logic       ack_in = 1'b0;
    logic       sfor0 = 1'b0;
    logic       sfor1 = 1'b0;
    logic [1:0] req_stat0 = 2'd0;
    logic [1:0] req_stat1 = 2'd0;
    logic       ack0;
    logic       ack1;
`ifdef RR_ACK_ERR_EN
    logic       ack_err;
`endif

    rr_ack_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .s_no      (s_no),
        .ack_in    (ack_in),
        .sfor0     (sfor0),
        .sfor1     (sfor1),
        .req_stat0 (req_stat0),
        .req_stat1 (req_stat1),
        .ack0      (ack0),
        .ack1      (ack1)
`ifdef RR_ACK_ERR_EN
        ,
        .ack_err   (ack_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic a0;
        logic a1;
        logic err;
        int   id;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   step_id = 0;
    bit   done = 1'b0;

    // Reference model state: which master was served last.
    // After reset master 1 counts as last served, so master 0 wins ties.
    int   last_served = 1;
    bit   prev_orphan = 1'b0;

    task automatic step(input bit r, input bit sn, input bit ai,
                        input bit f0, input bit f1,
                        input bit [1:0] st0, input bit [1:0] st1);
        exp_t e;
        bit   w0;
        bit   w1;
        int   winner;
        @(posedge clk);
        #1;
        rst = r;
        s_no = sn;
        ack_in = ai;
        sfor0 = f0;
        sfor1 = f1;
        req_stat0 = st0;
        req_stat1 = st1;
        w0 = (st0 == 2'd2) && (f0 == sn);
        w1 = (st1 == 2'd2) && (f1 == sn);
        winner = -1;
        if (!r && ai) begin
            if (w0 && w1) winner = 1 - last_served;
            else if (w0) winner = 0;
            else if (w1) winner = 1;
        end
        e.a0 = (winner == 0);
        e.a1 = (winner == 1);
        e.err = prev_orphan;
        e.id = step_id;
        exp_q.push_back(e);
        step_id++;
        if (r) last_served = 1;
        else if (winner >= 0) last_served = winner;
        prev_orphan = !r && ai && !w0 && !w1;
    endtask

    // Monitor: compares at the falling edge, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (ack0 !== e.a0 || ack1 !== e.a1) begin
                    errors++;
                    $display("FAIL acks step %0d: got ack0=%b ack1=%b want ack0=%b ack1=%b",
                             e.id, ack0, ack1, e.a0, e.a1);
                end
                checks++;
                if (ack0 === 1'b1 && ack1 === 1'b1) begin
                    errors++;
                    $display("FAIL onehot step %0d: got ack0=%b ack1=%b want not both",
                             e.id, ack0, ack1);
                end
`ifdef RR_ACK_ERR_EN
                checks++;
                if (ack_err !== e.err) begin
                    errors++;
                    $display("FAIL ack_err step %0d: got %b want %b",
                             e.id, ack_err, e.err);
                end
`endif
            end
        end
    end

    initial begin
        // Reset
        step(1, 0, 1, 0, 0, 2'd2, 2'd2);
        step(1, 0, 0, 0, 0, 2'd0, 2'd0);
        // Master 1 targets the other slave
        step(0, 0, 1, 0, 1, 2'd2, 2'd2);
        // Fresh reset, then ties alternate 0,1,0,1
        step(1, 0, 0, 0, 0, 2'd0, 2'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 2'd2, 2'd2);
        // Both eligible, no ack: priority must hold
        step(0, 0, 0, 0, 0, 2'd2, 2'd2);
        step(0, 0, 1, 0, 0, 2'd2, 2'd2);
        // Tie to 0, reset with ack_in high, tie again -> 0
        step(1, 0, 0, 0, 0, 2'd0, 2'd0);
        step(0, 0, 1, 0, 0, 2'd2, 2'd2);
        step(1, 0, 1, 0, 0, 2'd2, 2'd2);
        step(0, 0, 1, 0, 0, 2'd2, 2'd2);
        // Orphan ack, then idle
        step(0, 0, 1, 0, 0, 2'd0, 2'd0);
        step(0, 0, 0, 0, 0, 2'd0, 2'd0);
        step(0, 0, 0, 0, 0, 2'd0, 2'd0);
        // Full sweep of status and target pairs
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int f = 0; f < 4; f++)
                    step(0, 0, 1, f[0], f[1], 2'(a), 2'(b));
        // Same sweep for slave 1
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int f = 0; f < 4; f++)
                    step(0, 1, 1, f[0], f[1], 2'(a), 2'(b));
        // Random traffic; s_no stays fixed within each burst
        for (int blk = 0; blk < 8; blk++) begin
            bit sn;
            sn = 1'($urandom_range(0, 1));
            for (int i = 0; i < 50; i++) begin
                step(($urandom_range(0, 19) == 0), sn,
                     1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 2) == 0) ? 2'(2'd2) : 2'($urandom_range(0, 3)),
                     ($urandom_range(0, 2) == 0) ? 2'(2'd2) : 2'($urandom_range(0, 3)));
            end
        end
        // Drain the scoreboard with a bounded wait
        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
